// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the two-port memory read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_addr_w_default = 16;
    localparam int c_data_w_default = 16;
    localparam int c_cnt_w          = 4;

    // Requester indices
    localparam logic c_fetch = 1'b0;
    localparam logic c_data  = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_addr = 2'd1;
    localparam state_t c_st_wait = 2'd2;
    localparam state_t c_st_done = 2'd3;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter; on contention grants the requester
//            that was not served last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates fetch/data read requests onto one fixed-latency memory
//            port (MAR/LDMAR/MDR) using an IDLE-ADDR-WAIT-DONE sequence.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w_default,
    parameter int DATA_W      = c_data_w_default,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] MAR,
    output logic              LDMAR,
    input  logic [DATA_W-1:0] MDR,
    output logic              busy
);

    localparam logic [c_cnt_w-1:0] c_wait = WAIT_CYCLES[c_cnt_w-1:0];

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_winner;
    logic                r_last;

    logic [1:0]          w_gnt;
    logic [1:0]          w_grant_idle;

    rr_arb2 u_rr_arb2 (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    always_comb begin
        w_grant_idle = 2'b00;
        if (r_state == c_st_idle) begin
            w_grant_idle = w_gnt;
        end
    end

    // rst_n gates only the output so no grant is visible while reset is held
    assign req_ready = w_grant_idle & {2{rst_n}};
    assign rsp_valid = (r_state == c_st_done) ? idx_to_onehot(r_winner) : 2'b00;
    assign LDMAR     = (r_state == c_st_addr);
    assign busy      = (r_state != c_st_idle);
    assign MAR       = r_mar;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_mar      <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
            r_winner   <= c_fetch;
            r_last     <= c_data;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_grant_idle) begin
                        r_mar    <= w_grant_idle[1] ? req_addr1 : req_addr0;
                        r_winner <= w_grant_idle[1];
                        r_state  <= c_st_addr;
                    end
                end
                c_st_addr: begin
                    r_cnt <= c_wait;
                    if (c_wait == '0) begin
                        r_rsp_data <= MDR;
                        r_state    <= c_st_done;
                    end else begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 4'd1) begin
                        r_rsp_data <= MDR;
                        r_state    <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_last  <= r_winner;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
